player_motion: RTL and testbench

- Per-player motion engine between the controller debouncer and vga_bitchange.
- Consumes the 7-bit controller_inputs bus and advances position, jump arc, attack and shield timing once per game tick.
- Outputs registered player_x/player_y plus action state and facing for the renderer.
- Replaces the ad-hoc divided-clock movement loop; everything runs on clk.

---
 rtl/player_motion.sv | 241 ++++++++++++++++++++++++
 tb/tb_player_motion.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/player_motion.sv
// ============================================================================
//  Module   : player_motion
//  Purpose  : Per-player motion engine. Samples the debounced controller bus
//             once per game tick. On each tick it advances the horizontal
//             position, the jump arc, the attack timer and the shield/crouch
//             state. Outputs are registered for the renderer.
//  Ports    : clk               - system clock
//             rst               - asynchronous active-high reset
//             controller_inputs - [1] down [2] right [3] up [4] left
//                                 [5] attack [6] shield ([0] unused)
//             player_x/player_y - current position (y grows downward)
//             facing            - 1 = right, 0 = left
//             action            - 0 IDLE 1 WALK 2 CROUCH 3 JUMP 4 ATTACK
//                                 5 SHIELD
//             move_tick         - one-cycle pulse, first cycle of new outputs
//  Options  : PLAYER_MOTION_AIR_CTRL_EN - when defined, horizontal input
//             steers the player while airborne. Otherwise the direction is
//             latched at takeoff.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module player_motion #(
    parameter int TICK_DIV     = 1666667,
    parameter int X_START      = 300,
    parameter int X_MIN        = 16,
    parameter int X_MAX        = 600,
    parameter int GROUND_Y     = 300,
    parameter int WALK_SPEED   = 2,
    parameter int JUMP_V       = 12,
    parameter int ATTACK_TICKS = 10
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [6:0] controller_inputs,
    output logic      [9:0] player_x,
    output logic      [9:0] player_y,
    output logic            facing,
    output logic      [2:0] action,
    output logic            move_tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int ATK_W = (ATTACK_TICKS > 2) ? $clog2(ATTACK_TICKS) : 1;

    localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(TICK_DIV - 1);
    localparam logic [ATK_W-1:0] c_atk_init  = ATK_W'(ATTACK_TICKS - 1);
    localparam logic [9:0]       c_x_start   = 10'(X_START);
    localparam logic [9:0]       c_x_min     = 10'(X_MIN);
    localparam logic [9:0]       c_x_max     = 10'(X_MAX);
    localparam logic [9:0]       c_left_lim  = 10'(X_MIN + WALK_SPEED);
    localparam logic [9:0]       c_right_lim = 10'(X_MAX - WALK_SPEED);
    localparam logic [9:0]       c_step      = 10'(WALK_SPEED);
    localparam logic [9:0]       c_ground    = 10'(GROUND_Y);
    localparam logic [9:0]       c_jump_v10  = 10'(JUMP_V);
    localparam logic signed [5:0] c_jump_v1  = 6'(JUMP_V - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WALK   = 3'd1,
        S_CROUCH = 3'd2,
        S_JUMP   = 3'd3,
        S_ATTACK = 3'd4,
        S_SHIELD = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  r_cnt;
    logic              r_tick;
    state_t            r_state, w_state_nxt;
    logic [9:0]        r_x, w_x_nxt;
    logic [9:0]        r_y, w_y_nxt;
    logic signed [5:0] r_vy, w_vy_nxt;
    logic              r_facing, w_facing_nxt;
    logic [ATK_W-1:0]  r_atk_cnt, w_atk_cnt_nxt;
    logic              r_atk_prev;

`ifndef PLAYER_MOTION_AIR_CTRL_EN
    // Horizontal direction captured at takeoff and replayed every air tick.
    logic r_air_l, r_air_r, w_air_l_nxt, w_air_r_nxt;
`endif

    logic w_tick;
    logic w_down, w_right, w_up, w_left, w_atk, w_shd;
    logic w_dir_l, w_dir_r;
    logic [9:0] w_x_left, w_x_right, w_x_step;
    logic signed [10:0] w_ny;
    logic w_unused_bit0;

    assign w_tick        = (r_cnt == c_cnt_last);
    assign w_unused_bit0 = controller_inputs[0];
    assign w_down        = controller_inputs[1];
    assign w_right       = controller_inputs[2];
    assign w_up          = controller_inputs[3];
    assign w_left        = controller_inputs[4];
    assign w_atk         = controller_inputs[5];
    assign w_shd         = controller_inputs[6];

    // Opposing directions cancel; only an exclusive press counts as intent.
    assign w_dir_l = w_left & ~w_right;
    assign w_dir_r = w_right & ~w_left;

    // Clamped one-step positions. The comparisons run before the add/sub,
    // so the result can never wrap the 10-bit range.
    assign w_x_left  = (r_x < c_left_lim)  ? c_x_min : (r_x - c_step);
    assign w_x_right = (r_x > c_right_lim) ? c_x_max : (r_x + c_step);
    assign w_x_step  = w_dir_r ? w_x_right : (w_dir_l ? w_x_left : r_x);

    // Candidate y for the jump arc. Velocity is positive while rising.
    assign w_ny = $signed({1'b0, r_y}) - $signed({{5{r_vy[5]}}, r_vy});

    // ------------------------------------------------------------------
    // Tick divider and state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_tick     <= 1'b0;
            r_state    <= S_IDLE;
            r_x        <= c_x_start;
            r_y        <= c_ground;
            r_vy       <= '0;
            r_facing   <= 1'b1;
            r_atk_cnt  <= '0;
            r_atk_prev <= 1'b0;
        end else begin
            r_tick <= w_tick;
            if (w_tick) begin
                r_cnt      <= '0;
                r_state    <= w_state_nxt;
                r_x        <= w_x_nxt;
                r_y        <= w_y_nxt;
                r_vy       <= w_vy_nxt;
                r_facing   <= w_facing_nxt;
                r_atk_cnt  <= w_atk_cnt_nxt;
                r_atk_prev <= w_atk;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

`ifndef PLAYER_MOTION_AIR_CTRL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_air_l <= 1'b0;
            r_air_r <= 1'b0;
        end else if (w_tick) begin
            r_air_l <= w_air_l_nxt;
            r_air_r <= w_air_r_nxt;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_x_nxt       = r_x;
        w_y_nxt       = r_y;
        w_vy_nxt      = r_vy;
        w_facing_nxt  = r_facing;
        w_atk_cnt_nxt = r_atk_cnt;
`ifndef PLAYER_MOTION_AIR_CTRL_EN
        w_air_l_nxt   = r_air_l;
        w_air_r_nxt   = r_air_r;
`endif

        case (r_state)
            S_JUMP: begin
`ifdef PLAYER_MOTION_AIR_CTRL_EN
                w_x_nxt = w_x_step;
                if (w_dir_r | w_dir_l) begin
                    w_facing_nxt = w_dir_r;
                end
`else
                w_x_nxt = r_air_r ? w_x_right : (r_air_l ? w_x_left : r_x);
`endif
                if (w_ny >= $signed({1'b0, c_ground})) begin
                    // Landing tick: no re-jump even if up is still held.
                    w_y_nxt     = c_ground;
                    w_vy_nxt    = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_y_nxt  = w_ny[9:0];
                    w_vy_nxt = r_vy - 6'sd1;
                end
            end

            S_ATTACK: begin
                if (r_atk_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_atk_cnt_nxt = r_atk_cnt - ATK_W'(1);
                end
            end

            default: begin
                // Grounded: IDLE, WALK, CROUCH, SHIELD.
                if (w_dir_r | w_dir_l) begin
                    w_facing_nxt = w_dir_r;
                end
                if (w_up) begin
                    // The first rise step is applied on the takeoff tick.
                    w_state_nxt = S_JUMP;
                    w_x_nxt     = w_x_step;
                    w_y_nxt     = r_y - c_jump_v10;
                    w_vy_nxt    = c_jump_v1;
`ifndef PLAYER_MOTION_AIR_CTRL_EN
                    w_air_l_nxt = w_dir_l;
                    w_air_r_nxt = w_dir_r;
`endif
                end else if (w_atk && !r_atk_prev) begin
                    w_state_nxt   = S_ATTACK;
                    w_atk_cnt_nxt = c_atk_init;
                end else if (w_shd) begin
                    w_state_nxt = S_SHIELD;
                end else if (w_down) begin
                    w_state_nxt = S_CROUCH;
                end else if (w_dir_r | w_dir_l) begin
                    w_state_nxt = S_WALK;
                    w_x_nxt     = w_x_step;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    assign player_x  = r_x;
    assign player_y  = r_y;
    assign facing    = r_facing;
    assign action    = r_state;
    assign move_tick = r_tick;

endmodule

`default_nettype wire

// File: tb/tb_player_motion.sv
// ============================================================================
//  Module   : tb_player_motion
//  Purpose  : Directed testbench for player_motion with hand-computed
//             expectations. Parameters: TICK_DIV=4, X_MAX=306, JUMP_V=3,
//             ATTACK_TICKS=4.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_player_motion;

    localparam logic [6:0] c_none  = 7'b0000000;
    localparam logic [6:0] c_down  = 7'b0000010;
    localparam logic [6:0] c_right = 7'b0000100;
    localparam logic [6:0] c_up    = 7'b0001000;
    localparam logic [6:0] c_left  = 7'b0010000;
    localparam logic [6:0] c_atk   = 7'b0100000;
    localparam logic [6:0] c_shd   = 7'b1000000;

`ifdef PLAYER_MOTION_AIR_CTRL_EN
    localparam int c_x_air3 = 302;
    localparam int c_x_air4 = 304;
    localparam int c_f_air  = 1;
`else
    localparam int c_x_air3 = 300;
    localparam int c_x_air4 = 300;
    localparam int c_f_air  = 0;
`endif

    logic       clk;
    logic       rst;
    logic [6:0] controller_inputs;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic       facing;
    logic [2:0] action;
    logic       move_tick;

    int checks;
    int errors;

    player_motion #(
        .TICK_DIV    (4),
        .X_START     (300),
        .X_MIN       (16),
        .X_MAX       (306),
        .GROUND_Y    (300),
        .WALK_SPEED  (2),
        .JUMP_V      (3),
        .ATTACK_TICKS(4)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .controller_inputs(controller_inputs),
        .player_x         (player_x),
        .player_y         (player_y),
        .facing           (facing),
        .action           (action),
        .move_tick        (move_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Apply inputs, then return at the negedge where move_tick is high,
    // i.e. once the outputs of that tick are visible.
    task automatic tick_in(input logic [6:0] ci);
        bit seen;
        seen = 1'b0;
        controller_inputs = ci;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (move_tick) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("tick_timeout", 0, 1);
    endtask

    task automatic tick_chk(input logic [6:0] ci, input string tag,
                            input int ex, input int ey, input int ea,
                            input int ef);
        tick_in(ci);
        check({tag, "_x"},   int'(player_x), ex);
        check({tag, "_y"},   int'(player_y), ey);
        check({tag, "_act"}, int'(action),   ea);
        check({tag, "_fac"}, int'(facing),   ef);
    endtask

    // Negedges from now until move_tick is seen high.
    task automatic period(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (move_tick) break;
        end
    endtask

    int n;
    int xf;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        controller_inputs = c_none;
        repeat (3) @(negedge clk);
        check("rst_x",    int'(player_x),  300);
        check("rst_y",    int'(player_y),  300);
        check("rst_act",  int'(action),    0);
        check("rst_fac",  int'(facing),    1);
        check("rst_tick", int'(move_tick), 0);
        rst = 1'b0;

        // Tick phase starts at 0: first pulse after 4 clocks, then every 4.
        period(n);
        check("first_tick_period", n, 4);
        period(n);
        check("tick_period", n, 4);
        @(negedge clk);
        check("tick_one_cycle", int'(move_tick), 0);
        check("idle_act", int'(action), 0);

        // Walk right into the X_MAX clamp.
        tick_chk(c_right, "r1", 302, 300, 1, 1);
        tick_chk(c_right, "r2", 304, 300, 1, 1);
        tick_chk(c_right, "r3", 306, 300, 1, 1);
        tick_chk(c_right, "r4", 306, 300, 1, 1);
        tick_chk(c_right, "r5", 306, 300, 1, 1);

        // Opposing directions cancel.
        tick_chk(c_left | c_right, "lr1", 306, 300, 0, 1);
        tick_chk(c_left | c_right, "lr2", 306, 300, 0, 1);

        // Shield and crouch hold position even with a direction pressed.
        tick_chk(c_shd | c_left, "shd", 306, 300, 5, 0);
        tick_chk(c_down | c_right, "crouch", 306, 300, 2, 1);

        // Walk left.
        tick_chk(c_left, "l1", 304, 300, 1, 0);
        tick_chk(c_left, "l2", 302, 300, 1, 0);
        tick_chk(c_left, "l3", 300, 300, 1, 0);
        tick_chk(c_none, "idle", 300, 300, 0, 0);

        // Neutral jump, attack mid-air ignored, right pressed mid-air.
        tick_chk(c_up,    "j1", 300,      297, 3, 0);
        tick_chk(c_atk,   "j2", 300,      295, 3, 0);
        tick_chk(c_right, "j3", c_x_air3, 294, 3, c_f_air);
        tick_chk(c_right, "j4", c_x_air4, 294, 3, c_f_air);
        tick_chk(c_none,  "j5", c_x_air4, 295, 3, c_f_air);
        tick_chk(c_none,  "j6", c_x_air4, 297, 3, c_f_air);
        tick_chk(c_none,  "j7", c_x_air4, 300, 0, c_f_air);
        xf = c_x_air4;

        // Attack held 15 ticks: exactly 4 ticks of ATTACK, no retrigger.
        for (int t = 1; t <= 15; t++) begin
            tick_chk(c_atk, $sformatf("atk%0d", t), xf, 300,
                     (t <= 4) ? 4 : 0, c_f_air);
        end
        tick_chk(c_none, "atk_rel", xf, 300, 0, c_f_air);
        tick_chk(c_atk,  "atk_re",  xf, 300, 4, c_f_air);
        tick_chk(c_atk | c_right, "atk_frz", xf, 300, 4, c_f_air);

        // Reset mid-attack restores reset values immediately.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst_x",   int'(player_x), 300);
        check("mrst_y",   int'(player_y), 300);
        check("mrst_act", int'(action),   0);
        check("mrst_fac", int'(facing),   1);
        @(negedge clk);
        controller_inputs = c_none;
        rst = 1'b0;
        period(n);
        check("mrst_period", n, 4);
        check("mrst_act2", int'(action), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
